// File: rtl/mesh_16_3_outlet_sampler.sv
// Outlet sampler: scans mesh outlets one at a time. Each outlet's valve is opened and allowed
// to settle, then the sensor is sampled and the result is buffered in a small FWFT FIFO.
module mesh_16_3_outlet_sampler #(
    parameter int NUM_OUTLETS   = 16,
    parameter int SETTLE_CYCLES = 8,
    parameter int SAMPLE_W      = 12,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    output logic [NUM_OUTLETS-1:0] sel_valve,
    output logic                   sensor_req,
    input  logic                   sensor_ack,
    input  logic [SAMPLE_W-1:0]    sensor_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [3:0]             out_idx,
    output logic [SAMPLE_W-1:0]    out_data,
    output logic                   busy,
    output logic                   done
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {IDLE, SETTLE, SAMPLE, PUSH, DONE} state_t;

    state_t              state;
    logic [3:0]          idx;
    logic [7:0]          cnt;
    logic [SAMPLE_W-1:0] sample;

    logic [3:0]          mem_idx  [FIFO_DEPTH];
    logic [SAMPLE_W-1:0] mem_data [FIFO_DEPTH];
    logic [AW-1:0]       wptr, rptr;
    logic [CW-1:0]       count;
    logic                push, pop;

    // Push admission looks only at the count at cycle start, so a pop at full does not free a slot early.
    assign push      = (state == PUSH) && (count != CW'(FIFO_DEPTH));
    assign pop       = (count != '0) && out_ready;
    assign out_valid = (count != '0);
    assign out_idx   = mem_idx[rptr];
    assign out_data  = mem_data[rptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= '0;
            cnt        <= '0;
            sample     <= '0;
            sel_valve  <= '0;
            sensor_req <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        idx       <= '0;
                        sel_valve <= NUM_OUTLETS'(1);
                        cnt       <= 8'(SETTLE_CYCLES - 1);
                        busy      <= 1'b1;
                        state     <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (cnt == '0) begin
                        sensor_req <= 1'b1;
                        state      <= SAMPLE;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                SAMPLE: begin
                    if (sensor_ack) begin
                        sample     <= sensor_data;
                        sensor_req <= 1'b0;
                        state      <= PUSH;
                    end
                end
                PUSH: begin
                    if (push) begin
                        if (idx == 4'(NUM_OUTLETS - 1)) begin
                            sel_valve <= '0;
                            done      <= 1'b1;
                            state     <= DONE;
                        end else begin
                            idx       <= idx + 4'd1;
                            sel_valve <= sel_valve << 1;
                            cnt       <= 8'(SETTLE_CYCLES - 1);
                            state     <= SETTLE;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_idx[i]  <= '0;
                mem_data[i] <= '0;
            end
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                mem_idx[wptr]  <= idx;
                mem_data[wptr] <= sample;
                wptr           <= wptr + 1'b1;
            end
            if (pop)
                rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_mesh_16_3_outlet_sampler.sv
// Bench for the outlet sampler: a sensor model feeds an expected-result queue, a consumer pops
// and scores results, and directed sequences cover stall, long ack, reset and held-start cases.
module tb_mesh_16_3_outlet_sampler;
    localparam int NUM_OUTLETS   = 16;
    localparam int SETTLE_CYCLES = 8;
    localparam int SAMPLE_W      = 12;
    localparam int FIFO_DEPTH    = 4;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   start = 1'b0;
    logic [NUM_OUTLETS-1:0] sel_valve;
    logic                   sensor_req;
    logic                   sensor_ack;
    logic [SAMPLE_W-1:0]    sensor_data;
    logic                   out_valid;
    logic                   out_ready;
    logic [3:0]             out_idx;
    logic [SAMPLE_W-1:0]    out_data;
    logic                   busy;
    logic                   done;

    mesh_16_3_outlet_sampler #(
        .NUM_OUTLETS(NUM_OUTLETS), .SETTLE_CYCLES(SETTLE_CYCLES),
        .SAMPLE_W(SAMPLE_W), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .sel_valve(sel_valve),
        .sensor_req(sensor_req), .sensor_ack(sensor_ack), .sensor_data(sensor_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
        .out_data(out_data), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int ready_mode = 0;     // 0: always ready, 1: random, 2: never
    int ack_delay = 2;      // negative: random 0..4
    int special_idx = -1, special_delay = 0;
    int next_idx = 0, done_cnt = 0, pops = 0, req80 = 0;
    logic [15:0] exp_q[$];

    typedef struct {
        int ack_dly;
        int rmode;
        int exp_res;
        int exp_done;
    } vec_t;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Sensor model: answers each request after a delay and records the expected result.
    logic [15:0] s_sel;
    logic [11:0] s_data;
    int          s_cur, s_dly;
    bit          s_abort;
    initial begin
        sensor_ack = 1'b0;
        sensor_data = '0;
        forever begin
            @(negedge clk);
            if (!rst && sensor_req && !sensor_ack) begin
                chk("valve_order", sel_valve, 16'(1) << next_idx);
                s_sel = sel_valve;
                s_cur = next_idx;
                next_idx++;
                s_dly = (s_cur == special_idx) ? special_delay :
                        (ack_delay < 0) ? int'($urandom_range(0, 4)) : ack_delay;
                s_abort = 1'b0;
                for (int k = 0; k < s_dly; k++) begin
                    @(negedge clk);
                    if (rst) begin
                        s_abort = 1'b1;
                        break;
                    end
                end
                if (!s_abort) begin
                    chk("req_held", sensor_req, 1);
                    chk("valve_hold", sel_valve, s_sel);
                    s_data = 12'($urandom);
                    sensor_ack = 1'b1;
                    sensor_data = s_data;
                    exp_q.push_back({4'(s_cur), s_data});
                    @(negedge clk);
                    sensor_ack = 1'b0;
                end
            end
        end
    end

    // Consumer and scoreboard.
    bit          held = 1'b0;
    logic [15:0] held_v;
    initial begin
        out_ready = 1'b0;
        forever begin
            @(negedge clk);
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
            if (rst) begin
                held = 1'b0;
            end else begin
                if (held && out_valid)
                    chk("head_stable", {out_idx, out_data}, held_v);
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) chk("pop_queue_size", exp_q.size(), 1);
                    else begin
                        chk("pop_data", {out_idx, out_data}, exp_q.pop_front());
                        pops++;
                    end
                end
                held = out_valid && !out_ready;
                held_v = {out_idx, out_data};
                chk("occupancy", exp_q.size() <= FIFO_DEPTH + 1, 1);
            end
        end
    end

    // Structural monitor: valve encoding, done pulse shape, scan length.
    logic prev_done = 1'b0;
    always @(negedge clk) begin
        if (!rst) begin
            chk("onehot", (sel_valve == '0) || $onehot(sel_valve), 1);
            if (!busy) chk("idle_valve", sel_valve, 0);
            if (sensor_req && sel_valve == 16'h0080) req80++;
            if (done) begin
                chk("done_len", prev_done, 0);
                chk("done_busy", busy, 1);
                chk("scan_len", next_idx, NUM_OUTLETS);
                next_idx = 0;
                done_cnt++;
            end
            prev_done = done;
        end else begin
            prev_done = 1'b0;
        end
    end

    task automatic start_pulse();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_scan(input string tag, input int pops0, input int done0,
                             input int exp_res, input int exp_done);
        int t = 0;
        while (done_cnt < done0 + exp_done && t < 4000) begin @(negedge clk); t++; end
        while (exp_q.size() != 0 && t < 5000) begin @(negedge clk); t++; end
        repeat (4) @(negedge clk);
        chk({tag, "_timeout"}, t < 5000, 1);
        chk({tag, "_results"}, pops - pops0, exp_res);
        chk({tag, "_dones"}, done_cnt - done0, exp_done);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_valid"}, out_valid, 0);
    endtask

    vec_t vecs[5];
    int p0, d0, rise, seen, t;

    initial begin
        vecs[0] = '{2, 0, 16, 1};
        vecs[1] = '{0, 0, 16, 1};
        vecs[2] = '{4, 1, 16, 1};
        vecs[3] = '{1, 1, 16, 1};
        vecs[4] = '{-1, 1, 16, 1};

        #1;
        chk("rst_sel", sel_valve, 0);
        chk("rst_req", sensor_req, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_idx", out_idx, 0);
        chk("rst_data", out_data, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Request latency and basic scan.
        ready_mode = 0; ack_delay = 2;
        p0 = pops; d0 = done_cnt; rise = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            if (k > 1) @(negedge clk);
            if (sensor_req && rise == 0) rise = k;
        end
        chk("req_latency", rise, SETTLE_CYCLES + 1);
        wait_scan("basic", p0, d0, 16, 1);

        for (int v = 0; v < 5; v++) begin
            ack_delay = vecs[v].ack_dly;
            ready_mode = vecs[v].rmode;
            p0 = pops; d0 = done_cnt;
            start_pulse();
            wait_scan($sformatf("vec%0d", v), p0, d0, vecs[v].exp_res, vecs[v].exp_done);
        end

        // Back-pressure: FIFO fills, FSM parks in PUSH at outlet 4.
        ready_mode = 2; ack_delay = 2;
        p0 = pops; d0 = done_cnt;
        start_pulse();
        repeat (200) @(negedge clk);
        chk("stall_sel", sel_valve, 16'h0010);
        chk("stall_valid", out_valid, 1);
        chk("stall_head", out_idx, 0);
        chk("stall_pending", exp_q.size(), 5);
        chk("stall_busy", busy, 1);
        chk("stall_req", sensor_req, 0);
        ready_mode = 0;
        wait_scan("stall", p0, d0, 16, 1);

        // Long ack at outlet 7.
        special_idx = 7; special_delay = 49; req80 = 0;
        p0 = pops; d0 = done_cnt;
        start_pulse();
        wait_scan("longack", p0, d0, 16, 1);
        chk("longack_req_cycles", req80, 50);
        special_idx = -1;

        // Reset while sampling outlet 5.
        special_idx = 5; special_delay = 30;
        start_pulse();
        t = 0;
        while (!(sensor_req && sel_valve == 16'h0020) && t < 500) begin @(negedge clk); t++; end
        chk("rst_reach_idx5", t < 500, 1);
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_sel", sel_valve, 0);
        chk("mid_rst_req", sensor_req, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_idx", out_idx, 0);
        chk("mid_rst_data", out_data, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        next_idx = 0;
        special_idx = -1;
        p0 = pops; d0 = done_cnt;
        start_pulse();
        wait_scan("after_rst", p0, d0, 16, 1);

        // Start held high: one scan per IDLE visit.
        ready_mode = 0; ack_delay = 1;
        p0 = pops; d0 = done_cnt; seen = 0; t = 0;
        @(negedge clk);
        start = 1'b1;
        while (seen < 2 && t < 4000) begin
            @(negedge clk);
            t++;
            if (done) seen++;
        end
        start = 1'b0;
        wait_scan("held_start", p0, d0, 32, 2);

        // Random ready and ack timing.
        ready_mode = 1; ack_delay = -1;
        for (int r = 0; r < 3; r++) begin
            p0 = pops; d0 = done_cnt;
            start_pulse();
            wait_scan($sformatf("rand%0d", r), p0, d0, 16, 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mesh_16_3_outlet_sampler.md
MESH_16_3_OUTLET_SAMPLER -- requirements
Module: mesh_16_3_outlet_sampler

Interface
REQ-001 SHALL have parameter NUM_OUTLETS, default 16: number of mesh outlets scanned; fixed to 16 in this revision.
REQ-002 SHALL have parameter SETTLE_CYCLES, default 8: cycles an outlet valve is held open before sensing; legal range 1..255.
REQ-003 SHALL have parameter SAMPLE_W, default 12: sensor sample width.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4: result buffer entries; power of two.
REQ-005 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port start  input  1  scan request, sampled in IDLE only.
REQ-008 SHALL have port sel_valve  output  16  one-hot outlet valve enable, bit i routes mesh output_i to the sensor.
REQ-009 SHALL have port sensor_req  output  1  sample request to sensor front end.
REQ-010 SHALL have port sensor_ack  input  1  sensor_data valid this cycle.
REQ-011 SHALL have port sensor_data  input  SAMPLE_W  sensor reading.
REQ-012 SHALL have port out_valid  output  1  result available.
REQ-013 SHALL have port out_ready  input  1  downstream accepts result.
REQ-014 SHALL have port out_idx  output  4  outlet index of head result.
REQ-015 SHALL have port out_data  output  SAMPLE_W  sample of head result.
REQ-016 SHALL have port busy  output  1  high in any state except IDLE.
REQ-017 SHALL have port done  output  1  one-cycle pulse at scan completion.

Function
REQ-018 SHALL implement FSM states IDLE, SETTLE, SAMPLE, PUSH, DONE; all outputs registered.
REQ-019 IDLE + start=1: idx<=0, sel_valve<=16'h0001, settle counter<=SETTLE_CYCLES-1, go SETTLE; start ignored in every other state.
REQ-020 SETTLE: counter decrements each cycle; when counter==0, go SAMPLE with sensor_req<=1; sensor_req therefore first high SETTLE_CYCLES+1 cycles after the start edge.
REQ-021 SAMPLE: sensor_req held high until sensor_ack=1; on that edge capture sensor_data, sensor_req<=0, go PUSH; sensor_ack outside SAMPLE ignored.
REQ-022 PUSH: if FIFO count<FIFO_DEPTH at cycle start, write {idx, captured sample}; then if idx==15 go DONE, else idx<=idx+1, sel_valve<=sel_valve<<1, counter reload, go SETTLE.
REQ-023 PUSH with FIFO full: stall in PUSH, sel_valve unchanged, no sample lost or overwritten, until a pop frees an entry.
REQ-024 DONE: sel_valve<=0, done=1 for exactly one cycle, go IDLE; done and next start may not overlap (start in DONE ignored).
REQ-025 sel_valve SHALL be exactly one-hot in SETTLE/SAMPLE/PUSH and all-zero in IDLE/DONE; never two valves open.
REQ-026 FIFO first-word-fall-through: out_valid=(count!=0); out_idx/out_data show head entry; pop when out_valid&&out_ready.
REQ-027 Simultaneous push and pop with 0<count<FIFO_DEPTH: count unchanged, order preserved; pop at full does not admit a push in the same cycle.
REQ-028 Pointers wrap modulo FIFO_DEPTH; out_idx/out_data stable while out_valid=1 and out_ready=0.
REQ-029 Full scan produces exactly 16 results, indices 0..15 in ascending order.

Reset
REQ-030 rst=1 SHALL immediately force: state IDLE, sel_valve=0, sensor_req=0, busy=0, done=0, out_valid=0, FIFO emptied, idx=0, counter=0, out_idx=0, out_data=0.
REQ-031 rst asserted mid-scan SHALL abandon the scan with no further results; first start after release begins at outlet 0.

Verification
REQ-032 SETTLE_CYCLES=8, start pulse, sensor_ack 2 cycles after each req, out_ready=1 -> sensor_req rises 9 cycles after start; 16 results idx 0..15 with matching data; one done pulse; busy low after.
REQ-033 out_ready=0 whole scan -> 4 results buffered, FSM stalls in PUSH at idx 4 with sel_valve=16'h0010; releasing out_ready completes scan with no loss or reordering.
REQ-034 sensor_ack delayed 50 cycles at idx 7 -> sensor_req held high 50 cycles, sel_valve=16'h0080 throughout, no extra results.
REQ-035 rst asserted during SAMPLE at idx 5 -> all outputs zero same cycle; new start yields idx 0 first with sel_valve=16'h0001.
REQ-036 start held high continuously -> exactly one scan per IDLE visit; start during busy/DONE creates no extra results.
REQ-037 Toggle out_ready randomly with simultaneous push/pop at count 1..3 -> scoreboard matches, count never exceeds 4, sel_valve always one-hot or zero.
